// File: rtl/sprite_pkg.sv
//------------------------------------------------------------------------------
// sprite_pkg: shared types, defaults and the built-in sprite asset.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sprite_pkg;

    localparam int DEF_COLOR_W = 4;
    localparam int DEF_IDX_W   = 3;

    typedef enum logic [1:0] {
        ROT_0   = 2'b00,
        ROT_90  = 2'b01,
        ROT_180 = 2'b10,
        ROT_270 = 2'b11
    } rot_e;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    // Default asset: an 8-colour diagonal stripe pattern, palette index per ROM word.
    function automatic int sprite_texel(int a);
        return (3 * a + 5 * (a >>> 3) + 5) % 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_rom.sv
//------------------------------------------------------------------------------
// sprite_rom: sprite texel ROM, one palette index per word, 1-cycle registered read.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sprite_rom
    import sprite_pkg::*;
#(
    parameter int DEPTH     = 1200,
    parameter int IDX_W     = DEF_IDX_W,
    parameter     INIT_FILE = "sprite.mif"
) (
    input  logic                     clock,
    input  logic [$clog2(DEPTH)-1:0] address,
    output logic [IDX_W-1:0]         q
);

    logic [IDX_W-1:0] mem [DEPTH];

    generate
        if (INIT_FILE == "sprite.mif") begin : g_asset
            for (genvar a = 0; a < DEPTH; a++) begin : g_word
                assign mem[a] = IDX_W'(sprite_texel(a));
            end
        end else begin : g_empty
            for (genvar a = 0; a < DEPTH; a++) begin : g_word
                assign mem[a] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        q <= mem[address];
    end

endmodule

`default_nettype wire

// File: rtl/sprite_renderer.sv
//------------------------------------------------------------------------------
// sprite_renderer: draws one scaled/rotated paletted sprite over a background pixel stream.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W       = 40,
    parameter int SPR_H       = 30,
    parameter int SCALE_SHIFT = 0,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int COLOR_W     = DEF_COLOR_W,
    parameter int TRANSP_IDX  = 0,
    parameter     INIT_FILE   = "sprite.mif"
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic                 blank,
    input  logic [9:0]           pos_x,
    input  logic [9:0]           pos_y,
    input  logic [1:0]           rot,
    input  logic                 sprite_en,
    input  logic [3*COLOR_W-1:0] bg_rgb,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 hit
);

    localparam int DEPTH      = SPR_W * SPR_H;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int FOOT_W_0   = SPR_W << SCALE_SHIFT;
    localparam int FOOT_H_0   = SPR_H << SCALE_SHIFT;
    localparam int FOOT_W_ROT = SPR_H << SCALE_SHIFT;
    localparam int FOOT_H_ROT = SPR_W << SCALE_SHIFT;

    logic [9:0]           shadow_px;
    logic [9:0]           shadow_py;
    rot_e                 shadow_rot;
    logic                 shadow_en;

    logic                 fs;
    logic [9:0]           cur_px;
    logic [9:0]           cur_py;
    rot_e                 cur_rot;
    logic                 cur_en;
    logic [10:0]          dx;
    logic [10:0]          dy;
    int                   foot_w;
    int                   foot_h;
    int                   u;
    int                   v;
    int                   sx;
    int                   sy;
    logic                 inbox;
    logic [ADDR_W-1:0]    addr_next;

    logic [ADDR_W-1:0]    addr_q;
    logic                 inbox_d1;
    logic                 inbox_d2;
    logic                 blank_d1;
    logic                 blank_d2;
    logic [3*COLOR_W-1:0] bg_d1;
    logic [3*COLOR_W-1:0] bg_d2;
    logic [IDX_W-1:0]     idx;
    logic [3*COLOR_W-1:0] pal;

    // Pixel (0,0) must already see the new placement, so stage 0 bypasses the shadows there.
    always_comb begin
        fs      = (DrawX == 10'd0) && (DrawY == 10'd0);
        cur_px  = fs ? pos_x : shadow_px;
        cur_py  = fs ? pos_y : shadow_py;
        cur_rot = fs ? rot_e'(rot) : shadow_rot;
        cur_en  = fs ? sprite_en : shadow_en;

        dx      = {1'b0, DrawX} - {1'b0, cur_px};
        dy      = {1'b0, DrawY} - {1'b0, cur_py};
        foot_w  = cur_rot[0] ? FOOT_W_ROT : FOOT_W_0;
        foot_h  = cur_rot[0] ? FOOT_H_ROT : FOOT_H_0;
        inbox   = cur_en && !dx[10] && !dy[10]
                  && (int'(dx[9:0]) < foot_w) && (int'(dy[9:0]) < foot_h);

        u       = int'(dx[9:0]) >> SCALE_SHIFT;
        v       = int'(dy[9:0]) >> SCALE_SHIFT;
        sx      = 0;
        sy      = 0;
        case (cur_rot)
            ROT_0: begin
                sx = u;
                sy = v;
            end
            ROT_90: begin
                sx = v;
                sy = SPR_H - 1 - u;
            end
            ROT_180: begin
                sx = SPR_W - 1 - u;
                sy = SPR_H - 1 - v;
            end
            default: begin
                sx = SPR_W - 1 - v;
                sy = u;
            end
        endcase
        addr_next = inbox ? ADDR_W'(sy * SPR_W + sx) : '0;
    end

    sprite_rom #(
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clock   (vga_clk),
        .address (addr_q),
        .q       (idx)
    );

    always_comb begin
        pal = '0;
        case (int'(idx))
            1:       pal = {COLOR_W'(4'hF), COLOR_W'(4'h0), COLOR_W'(4'h0)};
            2:       pal = {COLOR_W'(4'h0), COLOR_W'(4'hF), COLOR_W'(4'h0)};
            3:       pal = {COLOR_W'(4'h0), COLOR_W'(4'h0), COLOR_W'(4'hF)};
            4:       pal = {COLOR_W'(4'hF), COLOR_W'(4'hF), COLOR_W'(4'h0)};
            5:       pal = {COLOR_W'(4'h0), COLOR_W'(4'hF), COLOR_W'(4'hF)};
            6:       pal = {COLOR_W'(4'hF), COLOR_W'(4'h0), COLOR_W'(4'hF)};
            7:       pal = {COLOR_W'(4'h8), COLOR_W'(4'h8), COLOR_W'(4'h8)};
            default: pal = '0;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_px  <= '0;
            shadow_py  <= '0;
            shadow_rot <= ROT_0;
            shadow_en  <= 1'b0;
            addr_q     <= '0;
            inbox_d1   <= 1'b0;
            inbox_d2   <= 1'b0;
            blank_d1   <= 1'b0;
            blank_d2   <= 1'b0;
            bg_d1      <= '0;
            bg_d2      <= '0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            hit        <= 1'b0;
        end else begin
            if (fs) begin
                shadow_px  <= pos_x;
                shadow_py  <= pos_y;
                shadow_rot <= rot_e'(rot);
                shadow_en  <= sprite_en;
            end

            addr_q   <= addr_next;
            inbox_d1 <= inbox;
            blank_d1 <= blank;
            bg_d1    <= bg_rgb;

            inbox_d2 <= inbox_d1;
            blank_d2 <= blank_d1;
            bg_d2    <= bg_d1;

            if (!blank_d2) begin
                {red, green, blue} <= '0;
                hit                <= 1'b0;
            end else if (inbox_d2 && (idx != IDX_W'(TRANSP_IDX))) begin
                {red, green, blue} <= pal;
                hit                <= 1'b1;
            end else begin
                {red, green, blue} <= bg_d2;
                hit                <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
